// File: rtl/rx_packet_framer.sv
// -----------------------------------------------------------------------------
// rx_packet_framer
//
// Frames the serial reader's byte stream into fixed-size packets. It waits for
// a sync byte, collects four payload bytes MSB-first, and checks them against
// a trailing XOR checksum byte. A good packet is presented as one 32-bit word
// with a one-cycle strobe. Packets with a bad checksum, or that stall between
// bytes, are dropped, flagged with a one-cycle pulse and counted.
//
// Parameters:
//   SYNC_BYTE      - byte value that opens a packet
//   TIMEOUT_CYCLES - maximum idle clocks allowed between bytes inside a packet
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   rda          in   reader "byte available" level; a rising edge is one byte
//   data_in      in   reader data byte, valid while rda is high
//   pkt_valid    out  one-cycle pulse for a packet that passes its checksum
//   pkt_data     out  payload of the last good packet (byte 0 in [31:24])
//   err_checksum out  one-cycle pulse on checksum mismatch
//   err_timeout  out  one-cycle pulse on inter-byte timeout mid-packet
//   drop_count   out  saturating count of dropped packets
// -----------------------------------------------------------------------------
module rx_packet_framer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rda,
    input  logic [7:0]  data_in,
    output logic        pkt_valid,
    output logic [31:0] pkt_data,
    output logic        err_checksum,
    output logic        err_timeout,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t      state_r;
    logic        rda_q_r;
    logic [1:0]  idx_r;
    logic [31:0] shift_r;
    logic [7:0]  xsum_r;
    logic [19:0] tmo_r;

    logic        byte_evt_s;
    logic        tmo_expire_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

    // Byte event on the rising edge of rda; timeout expiry only when no byte
    // arrives in the same cycle, so a byte on the expiry cycle always wins.
    always_comb begin
        byte_evt_s   = 1'b0;
        tmo_expire_s = 1'b0;
        if (rda && !rda_q_r) begin
            byte_evt_s = 1'b1;
        end else begin
            byte_evt_s = 1'b0;
        end
        if ((state_r != ST_HUNT) && !byte_evt_s &&
            (tmo_r == (TIMEOUT_CYCLES - 20'd1))) begin
            tmo_expire_s = 1'b1;
        end else begin
            tmo_expire_s = 1'b0;
        end
    end

    // Delayed copy of rda for edge detection; resets low so a level already
    // high at reset release counts as one byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rda_q_r <= 1'b0;
        end else begin
            rda_q_r <= rda;
        end
    end

    // Framing state machine with its registered strobes, payload and counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_HUNT;
            idx_r        <= 2'd0;
            shift_r      <= 32'h0000_0000;
            xsum_r       <= 8'h00;
            tmo_r        <= 20'd0;
            pkt_valid    <= 1'b0;
            pkt_data     <= 32'h0000_0000;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            drop_count   <= 8'h00;
        end else begin
            pkt_valid    <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            case (state_r)
                ST_HUNT: begin
                    // Non-sync bytes are discarded; the timer is idle here.
                    if (byte_evt_s && (data_in == SYNC_BYTE)) begin
                        state_r <= ST_PAYLOAD;
                        idx_r   <= 2'd0;
                        xsum_r  <= 8'h00;
                        tmo_r   <= 20'd0;
                    end
                end
                ST_PAYLOAD: begin
                    // A sync value here is ordinary payload, not a resync.
                    if (byte_evt_s) begin
                        shift_r <= {shift_r[23:0], data_in};
                        xsum_r  <= xsum_r ^ data_in;
                        tmo_r   <= 20'd0;
                        idx_r   <= idx_r + 2'd1;
                        if (idx_r == 2'd3) begin
                            state_r <= ST_CHECK;
                        end
                    end else if (tmo_expire_s) begin
                        err_timeout <= 1'b1;
                        drop_count  <= sat_inc8(drop_count);
                        tmo_r       <= 20'd0;
                        state_r     <= ST_HUNT;
                    end else begin
                        tmo_r <= tmo_r + 20'd1;
                    end
                end
                ST_CHECK: begin
                    if (byte_evt_s) begin
                        if (data_in == xsum_r) begin
                            pkt_data  <= shift_r;
                            pkt_valid <= 1'b1;
                        end else begin
                            err_checksum <= 1'b1;
                            drop_count   <= sat_inc8(drop_count);
                        end
                        tmo_r   <= 20'd0;
                        state_r <= ST_HUNT;
                    end else if (tmo_expire_s) begin
                        err_timeout <= 1'b1;
                        drop_count  <= sat_inc8(drop_count);
                        tmo_r       <= 20'd0;
                        state_r     <= ST_HUNT;
                    end else begin
                        tmo_r <= tmo_r + 20'd1;
                    end
                end
                default: begin
                    state_r <= ST_HUNT;
                    tmo_r   <= 20'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_packet_framer.sv
// -----------------------------------------------------------------------------
// tb_rx_packet_framer
//
// Directed and randomized byte streams for rx_packet_framer. A packet-level
// reference model (byte list, edge times, plain XOR) predicts every output
// pulse with its cycle and the payload word; a monitor records what the DUT
// produces and the two lists are compared at checkpoints.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rx_packet_framer;

    localparam int T = 100;

    logic        clk;
    logic        rst;
    logic        rda;
    logic [7:0]  data_in;
    logic        pkt_valid;
    logic [31:0] pkt_data;
    logic        err_checksum;
    logic        err_timeout;
    logic [7:0]  drop_count;

    rx_packet_framer #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (20'd100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rda          (rda),
        .data_in      (data_in),
        .pkt_valid    (pkt_valid),
        .pkt_data     (pkt_data),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .drop_count   (drop_count)
    );

    // kind: 1 = good packet, 2 = checksum error, 3 = timeout
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    ev_t         mon_e;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    // Reference model state
    bit          m_in_pkt;
    logic [7:0]  m_bytes[$];
    int          m_last;
    logic [31:0] m_data;
    int          m_drops;
    int          prev_high = 1;
    logic [7:0]  seq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse with the edge number that produced it.
    always @(negedge clk) begin
        mon_e.cyc  = cyc;
        mon_e.data = pkt_data;
        if (pkt_valid === 1'b1) begin
            mon_e.kind = 1;
            obs_q.push_back(mon_e);
        end
        if (err_checksum === 1'b1) begin
            mon_e.kind = 2;
            obs_q.push_back(mon_e);
        end
        if (err_timeout === 1'b1) begin
            mon_e.kind = 3;
            obs_q.push_back(mon_e);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] exp_drop();
        if (m_drops > 255) return 8'hFF;
        return m_drops[7:0];
    endfunction

    task automatic push_exp(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.data = m_data;
        exp_q.push_back(e);
    endtask

    // A packet in progress times out T edges after its last byte.
    task automatic model_flush(input int now);
        if (m_in_pkt && (m_last + T <= now)) begin
            m_drops++;
            push_exp(3, m_last + T);
            m_in_pkt = 1'b0;
        end
    endtask

    // One byte sampled on edge t.
    task automatic model_byte(input logic [7:0] b, input int t);
        logic [7:0] x;
        if (m_in_pkt && (t - m_last > T)) begin
            m_drops++;
            push_exp(3, m_last + T);
            m_in_pkt = 1'b0;
        end
        m_last = t;
        if (!m_in_pkt) begin
            if (b == 8'hA5) begin
                m_in_pkt = 1'b1;
                m_bytes.delete();
            end
        end else if (m_bytes.size() < 4) begin
            m_bytes.push_back(b);
        end else begin
            x = m_bytes[0] ^ m_bytes[1] ^ m_bytes[2] ^ m_bytes[3];
            if (b == x) begin
                m_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                push_exp(1, t);
            end else begin
                m_drops++;
                push_exp(2, t);
            end
            m_in_pkt = 1'b0;
        end
    endtask

    // rda low for 'low' cycles, then high with b for 'high' cycles.
    task automatic send_byte(input logic [7:0] b, input int low, input int high);
        rda = 1'b0;
        repeat (low) @(negedge clk);
        rda     = 1'b1;
        data_in = b;
        model_byte(b, cyc + 1);
        repeat (high) @(negedge clk);
        prev_high = high;
    endtask

    task automatic send_seq(input int low, input int high);
        foreach (seq[i]) send_byte(seq[i], low, high);
        seq.delete();
    endtask

    task automatic idle(input int n);
        rda = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic int rnd_low();
        if ($urandom_range(0, 11) == 0) return T - prev_high - 1 + int'($urandom_range(0, 2));
        return int'($urandom_range(1, 3));
    endfunction

    task automatic check_all(input string tag);
        #1;
        model_flush(cyc);
        chk32({tag, "_nev"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk32($sformatf("%s_ev%0d_kind", tag, i), obs_q[i].kind, exp_q[i].kind);
            chk32($sformatf("%s_ev%0d_cyc", tag, i), obs_q[i].cyc, exp_q[i].cyc);
            chk32($sformatf("%s_ev%0d_data", tag, i), obs_q[i].data, exp_q[i].data);
        end
        chk32({tag, "_drop"}, {24'd0, drop_count}, {24'd0, exp_drop()});
        chk32({tag, "_data"}, pkt_data, m_data);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        rda = 1'b0;
        repeat (2) @(negedge clk);
        chk32("rst_valid", {31'd0, pkt_valid}, 32'd0);
        chk32("rst_errck", {31'd0, err_checksum}, 32'd0);
        chk32("rst_errto", {31'd0, err_timeout}, 32'd0);
        chk32("rst_data", pkt_data, 32'd0);
        chk32("rst_drop", {24'd0, drop_count}, 32'd0);
        rst = 1'b1;
        m_in_pkt = 1'b0;
        m_bytes.delete();
        m_data  = 32'd0;
        m_drops = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          ng;
        int          keep;
        bit          skip_ck;
        logic [7:0]  b;
        logic [7:0]  x;

        rst     = 1'b0;
        rda     = 1'b0;
        data_in = 8'h00;
        do_reset();
        idle(3);
        check_all("reset");

        // Good packet
        seq = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_seq(1, 2);
        check_all("good");
        chk32("good_lit", pkt_data, 32'h1234_5678);

        // Bad checksum
        seq = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
        send_seq(2, 1);
        check_all("badck");
        chk32("badck_drop_lit", {24'd0, drop_count}, 32'd1);

        // Garbage then resync, sync value inside payload
        seq = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hA4};
        send_seq(1, 1);
        check_all("resync");
        chk32("resync_lit", pkt_data, 32'hA500_0001);

        // Stall mid-packet, then a fresh packet
        seq = '{8'hA5, 8'h11};
        send_seq(1, 2);
        idle(T + 10);
        check_all("stall");
        seq = '{8'hA5, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h08};
        send_seq(1, 1);
        check_all("after_stall");
        chk32("after_stall_lit", pkt_data, 32'h9ABC_DEF0);

        // Held rda level is a single byte
        send_byte(8'hA5, 1, 50);
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_seq(1, 1);
        check_all("held");

        // Byte exactly on the expiry cycle wins
        send_byte(8'hA5, 1, 1);
        send_byte(8'h05, 1, 1);
        send_byte(8'h06, T - 1, 1);
        seq = '{8'h07, 8'h08, 8'h0C};
        send_seq(1, 1);
        check_all("expiry_edge");
        chk32("expiry_edge_lit", pkt_data, 32'h0506_0708);

        // Reset after the third byte
        seq = '{8'hA5, 8'h01, 8'h02};
        send_seq(1, 1);
        do_reset();
        idle(T + 10);
        check_all("rst_mid");

        // Saturating drop counter
        for (int k = 0; k < 256; k++) begin
            seq = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
            send_seq(1, 1);
        end
        check_all("sat");
        chk32("sat_lit", {24'd0, drop_count}, 32'h0000_00FF);

        // Randomized streams
        do_reset();
        for (int p = 0; p < 40; p++) begin
            ng = int'($urandom_range(0, 2));
            for (int g = 0; g < ng; g++) begin
                send_byte(8'($urandom_range(0, 255)), rnd_low(), int'($urandom_range(1, 4)));
            end
            send_byte(8'hA5, rnd_low(), int'($urandom_range(1, 4)));
            keep    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : 4;
            skip_ck = ($urandom_range(0, 7) == 0);
            x = 8'h00;
            for (int i = 0; i < keep; i++) begin
                b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
                x = x ^ b;
                send_byte(b, rnd_low(), int'($urandom_range(1, 4)));
            end
            if (keep == 4 && !skip_ck) begin
                b = ($urandom_range(0, 1) == 1) ? x : (x ^ 8'($urandom_range(1, 255)));
                send_byte(b, rnd_low(), int'($urandom_range(1, 4)));
            end else begin
                idle(T + int'($urandom_range(1, 5)));
            end
            if ((p % 4) == 3) check_all($sformatf("rand%0d", p));
        end
        idle(T + 5);
        check_all("rand_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
